// File: rtl/data_bus_initiator.sv
// data_bus_initiator: issues single read/write cycles on the data_m peripheral
// bus from a valid/ready request channel. The result comes back on a valid/ready
// response channel. A bus cycle that gets no ack ends with an error after
// TIMEOUT_CYCLES.
module data_bus_initiator #(
  parameter int ADDR_WIDTH     = 19,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH:1]   req_addr,
  input  logic                  req_wr,
  input  logic [1:0]            req_bytesel,
  input  logic [15:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [15:0]           rsp_rdata,
  output logic                  rsp_error,
  output logic [ADDR_WIDTH:1]   data_m_addr,
  output logic [15:0]           data_m_data_out,
  input  logic [15:0]           data_m_data_in,
  output logic [1:0]            data_m_bytesel,
  output logic                  data_m_wr_en,
  output logic                  data_m_access,
  input  logic                  data_m_ack
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TMO_LAST =
    CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic TMO_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  access_q, access_d;
  logic                  wr_en_q, wr_en_d;
  logic [1:0]            bytesel_q, bytesel_d;
  logic [ADDR_WIDTH:1]   addr_q, addr_d;
  logic [15:0]           wdata_q, wdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [15:0]           rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_error_q, rsp_error_d;

  // Counter stops at all-ones so a disabled timeout never wraps.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  // Next-state and next-output decode for the request/access/respond sequence.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    access_d    = access_q;
    wr_en_d     = wr_en_q;
    bytesel_d   = bytesel_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_bytesel == 2'b00) begin
            // No lanes selected: reject without touching the bus.
            rsp_valid_d = 1'b1;
            rsp_error_d = 1'b1;
            rsp_rdata_d = 16'hFFFF;
            state_d     = RESPOND;
          end else begin
            addr_d    = req_addr;
            wdata_d   = req_wdata;
            wr_en_d   = req_wr;
            bytesel_d = req_bytesel;
            access_d  = 1'b1;
            cnt_d     = '0;
            state_d   = ACCESS;
          end
        end
      end
      ACCESS: begin
        cnt_d = sat_inc(cnt_q);
        if (data_m_ack || (TMO_EN && cnt_q == TMO_LAST)) begin
          // Ack takes priority over a timeout in the same cycle.
          access_d    = 1'b0;
          wr_en_d     = 1'b0;
          bytesel_d   = 2'b00;
          rsp_valid_d = 1'b1;
          rsp_error_d = !data_m_ack;
          if (!data_m_ack)
            rsp_rdata_d = 16'hFFFF;
          else
            rsp_rdata_d = wr_en_q ? 16'h0000 : data_m_data_in;
          state_d = RESPOND;
        end
      end
      RESPOND: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset drops the bus cycle immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      access_q    <= 1'b0;
      wr_en_q     <= 1'b0;
      bytesel_q   <= 2'b00;
      addr_q      <= '0;
      wdata_q     <= 16'h0000;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 16'h0000;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      access_q    <= access_d;
      wr_en_q     <= wr_en_d;
      bytesel_q   <= bytesel_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  assign req_ready       = (state_q == IDLE);
  assign rsp_valid       = rsp_valid_q;
  assign rsp_rdata       = rsp_rdata_q;
  assign rsp_error       = rsp_error_q;
  assign data_m_addr     = addr_q;
  assign data_m_data_out = wdata_q;
  assign data_m_bytesel  = bytesel_q;
  assign data_m_wr_en    = wr_en_q;
  assign data_m_access   = access_q;

endmodule
